// File: rtl/cam_pkg.sv
// cam_pkg: shared definitions for the CAM array.
//   cam_op_e   : operation accepted in a given cycle
//   cam_sel_op : fixed-priority select, flush > read > write > search
package cam_pkg;

  typedef enum logic [2:0] {
    CAM_OP_NONE,
    CAM_OP_FLUSH,
    CAM_OP_READ,
    CAM_OP_WRITE,
    CAM_OP_SEARCH
  } cam_op_e;

  // Only one operation wins per cycle; the losers are simply dropped.
  function automatic cam_op_e cam_sel_op(input logic flush, input logic rd,
                                         input logic wr, input logic srch);
    if (flush)     return CAM_OP_FLUSH;
    else if (rd)   return CAM_OP_READ;
    else if (wr)   return CAM_OP_WRITE;
    else if (srch) return CAM_OP_SEARCH;
    else           return CAM_OP_NONE;
  endfunction

endpackage

// File: rtl/cam_priority_encoder.sv
// cam_priority_encoder: combinational lowest-index encoder for the match vector.
//   match : DEPTH-bit match vector (bit i = entry i matched)
//   found : at least one bit set
//   index : lowest set bit index, 0 when none set
//   multi : two or more bits set
module cam_priority_encoder
  import cam_pkg::*;
#(
  parameter  int ADDR_WIDTH = 5,
  localparam int DEPTH      = 2**ADDR_WIDTH
) (
  input  logic [DEPTH-1:0]      match,
  output logic                  found,
  output logic [ADDR_WIDTH-1:0] index,
  output logic                  multi
);

  // Scan from the top so the lowest set bit is the last assignment.
  always_comb begin
    index = '0;
    for (int i = DEPTH-1; i >= 0; i--)
      if (match[i]) index = ADDR_WIDTH'(i);
  end

  assign found = |match;
  // Clearing the lowest set bit leaves something only if there were two.
  assign multi = |(match & (match - DEPTH'(1)));

endmodule

// File: rtl/cam_array.sv
// cam_array: DEPTH x WIDTH content-addressable memory with per-entry valid bits.
// One operation per cycle (flush > read > write > search); results are
// registered with one-cycle valid pulses, outputs hold when idle.
//   clk_i, reset_n_i            : clock, async active-low reset
//   flush_i                     : clear all valid bits
//   read_enable_i/read_index_i  : read request
//   write_enable_i/_index_i/_data_i : write request
//   search_enable_i/search_data_i   : search request
//   read_valid_o/_data_o/_hit_o     : read result
//   search_valid_o/_found_o/_index_o: search result (lowest matching index)
// Optional feature macro CAM_MULTI_HIT_EN adds search_multi_o and
// search_match_vec_o, registered alongside search_valid_o.
module cam_array
  import cam_pkg::*;
#(
  parameter  int WIDTH      = 32,
  parameter  int ADDR_WIDTH = 5,
  localparam int DEPTH      = 2**ADDR_WIDTH
) (
  input  logic                  clk_i,
  input  logic                  reset_n_i,
  input  logic                  flush_i,
  input  logic                  read_enable_i,
  input  logic [ADDR_WIDTH-1:0] read_index_i,
  input  logic                  write_enable_i,
  input  logic [ADDR_WIDTH-1:0] write_index_i,
  input  logic [WIDTH-1:0]      write_data_i,
  input  logic                  search_enable_i,
  input  logic [WIDTH-1:0]      search_data_i,
  output logic                  read_valid_o,
  output logic [WIDTH-1:0]      read_data_o,
  output logic                  read_hit_o,
  output logic                  search_valid_o,
  output logic                  search_found_o,
`ifdef CAM_MULTI_HIT_EN
  output logic                  search_multi_o,
  output logic [DEPTH-1:0]      search_match_vec_o,
`endif
  output logic [ADDR_WIDTH-1:0] search_index_o
);

  cam_op_e                 op;
  logic [WIDTH-1:0]        mem [DEPTH];
  logic [DEPTH-1:0]        valid;
  logic [DEPTH-1:0]        match;
  logic                    enc_found;
  logic [ADDR_WIDTH-1:0]   enc_index;
`ifdef CAM_MULTI_HIT_EN
  logic                    enc_multi;
`else
  logic                    enc_multi_unused;
`endif

  assign op = cam_sel_op(flush_i, read_enable_i, write_enable_i, search_enable_i);

  // Invalid entries are masked so stale storage can never match.
  always_comb begin
    match = '0;
    for (int i = 0; i < DEPTH; i++)
      match[i] = valid[i] && (mem[i] == search_data_i);
  end

  cam_priority_encoder #(.ADDR_WIDTH(ADDR_WIDTH)) u_enc (
    .match (match),
    .found (enc_found),
    .index (enc_index),
`ifdef CAM_MULTI_HIT_EN
    .multi (enc_multi)
`else
    .multi (enc_multi_unused)
`endif
  );

  // Storage is not reset; gating with reset_n_i keeps a write from
  // committing on an edge where reset is already asserted.
  always_ff @(posedge clk_i) begin
    if (reset_n_i && op == CAM_OP_WRITE)
      mem[write_index_i] <= write_data_i;
  end

  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      valid          <= '0;
      read_valid_o   <= 1'b0;
      read_data_o    <= '0;
      read_hit_o     <= 1'b0;
      search_valid_o <= 1'b0;
      search_found_o <= 1'b0;
      search_index_o <= '0;
`ifdef CAM_MULTI_HIT_EN
      search_multi_o     <= 1'b0;
      search_match_vec_o <= '0;
`endif
    end else begin
      read_valid_o   <= 1'b0;
      search_valid_o <= 1'b0;
      unique case (op)
        CAM_OP_FLUSH: valid <= '0;
        CAM_OP_READ: begin
          read_valid_o <= 1'b1;
          read_hit_o   <= valid[read_index_i];
          read_data_o  <= valid[read_index_i] ? mem[read_index_i] : '0;
        end
        CAM_OP_WRITE: valid[write_index_i] <= 1'b1;
        CAM_OP_SEARCH: begin
          search_valid_o <= 1'b1;
          search_found_o <= enc_found;
          search_index_o <= enc_index;
`ifdef CAM_MULTI_HIT_EN
          search_multi_o     <= enc_multi;
          search_match_vec_o <= match;
`endif
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_cam_array.sv
// tb_cam_array: self-checking bench for cam_array. Directed scenarios plus a
// randomized run, all checked against an array-based reference model.
module tb_cam_array;
  localparam int W  = 32;
  localparam int AW = 5;
  localparam int D  = 2**AW;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          flush = 1'b0, re = 1'b0, we = 1'b0, se = 1'b0;
  logic [AW-1:0] ri = '0, wi = '0;
  logic [W-1:0]  wd = '0, sd = '0;
  logic          rv, rh, sv, sf;
  logic [W-1:0]  rd;
  logic [AW-1:0] si;
`ifdef CAM_MULTI_HIT_EN
  logic          smulti;
  logic [D-1:0]  svec;
`endif

  int checks = 0;
  int failures = 0;

  // reference model
  logic [W-1:0]  m_mem [D];
  bit            m_vld [D];
  logic          e_rv, e_rh, e_sv, e_sf;
  logic [W-1:0]  e_rd;
  logic [AW-1:0] e_si;
  int            e_cnt;
  logic [D-1:0]  e_vec;

  always #5 clk = ~clk;

  cam_array #(.WIDTH(W), .ADDR_WIDTH(AW)) dut (
    .clk_i(clk), .reset_n_i(rst_n), .flush_i(flush),
    .read_enable_i(re), .read_index_i(ri),
    .write_enable_i(we), .write_index_i(wi), .write_data_i(wd),
    .search_enable_i(se), .search_data_i(sd),
    .read_valid_o(rv), .read_data_o(rd), .read_hit_o(rh),
    .search_valid_o(sv), .search_found_o(sf),
`ifdef CAM_MULTI_HIT_EN
    .search_multi_o(smulti), .search_match_vec_o(svec),
`endif
    .search_index_o(si)
  );

  task automatic model_reset();
    for (int i = 0; i < D; i++) m_vld[i] = 0;
    e_rv = 0; e_rh = 0; e_sv = 0; e_sf = 0; e_rd = '0; e_si = '0;
    e_cnt = 0; e_vec = '0;
  endtask

  // Drive one cycle of requests, advance the model, land #1 after the edge.
  task automatic drive(input bit f, input bit r, input bit w, input bit s,
                       input logic [AW-1:0] rix, input logic [AW-1:0] wix,
                       input logic [W-1:0] wdat, input logic [W-1:0] sdat);
    flush = f; re = r; we = w; se = s; ri = rix; wi = wix; wd = wdat; sd = sdat;
    e_rv = 0; e_sv = 0;
    if (f) begin
      for (int i = 0; i < D; i++) m_vld[i] = 0;
    end else if (r) begin
      e_rv = 1; e_rh = m_vld[rix]; e_rd = m_vld[rix] ? m_mem[rix] : '0;
    end else if (w) begin
      m_mem[wix] = wdat; m_vld[wix] = 1;
    end else if (s) begin
      e_sv = 1; e_sf = 0; e_si = '0; e_cnt = 0; e_vec = '0;
      for (int i = 0; i < D; i++)
        if (m_vld[i] && m_mem[i] == sdat) begin
          if (e_cnt == 0) e_si = AW'(i);
          e_cnt++; e_vec[i] = 1'b1;
        end
      e_sf = (e_cnt > 0);
    end
    @(posedge clk); #1;
    flush = 0; re = 0; we = 0; se = 0;
  endtask

  task automatic test_reset();
    rst_n = 0; model_reset();
    repeat (2) @(posedge clk);
    #1;
    checks++;
    if ({rv, rd, rh, sv, sf, si} !== '0) begin
      failures++;
      $display("FAIL reset_outputs got rv=%b rd=%h rh=%b sv=%b sf=%b si=%0d want all 0",
               rv, rd, rh, sv, sf, si);
    end
    #3 rst_n = 1;
    @(posedge clk); #1;
    drive(0, 0, 0, 1, '0, '0, '0, 32'h0);
    checks++;
    if (sv !== 1'b1 || sf !== 1'b0 || si !== '0) begin
      failures++;
      $display("FAIL search_empty got sv=%b sf=%b si=%0d want sv=1 sf=0 si=0", sv, sf, si);
    end
    @(posedge clk); #1;
    checks++;
    if (sv !== 1'b0 || sf !== 1'b0) begin
      failures++;
      $display("FAIL idle_hold got sv=%b sf=%b want sv=0 sf=0", sv, sf);
    end
  endtask

  task automatic test_write_read();
    drive(0, 0, 1, 0, '0, 5'd7, 32'hDEADBEEF, '0);
    checks++;
    if (rv !== 1'b0 || sv !== 1'b0) begin
      failures++;
      $display("FAIL write_no_pulse got rv=%b sv=%b want 0 0", rv, sv);
    end
    drive(0, 1, 0, 0, 5'd7, '0, '0, '0);
    checks++;
    if (rv !== 1'b1 || rh !== 1'b1 || rd !== 32'hDEADBEEF) begin
      failures++;
      $display("FAIL read7 got rv=%b rh=%b rd=%h want 1 1 deadbeef", rv, rh, rd);
    end
    drive(0, 1, 0, 0, 5'd8, '0, '0, '0);
    checks++;
    if (rv !== 1'b1 || rh !== 1'b0 || rd !== '0) begin
      failures++;
      $display("FAIL read_invalid got rv=%b rh=%b rd=%h want 1 0 0", rv, rh, rd);
    end
  endtask

  task automatic test_duplicate_search();
    drive(0, 0, 1, 0, '0, 5'd12, 32'hCAFE0001, '0);
    drive(0, 0, 1, 0, '0, 5'd3,  32'hCAFE0001, '0);
    drive(0, 0, 0, 1, '0, '0, '0, 32'hCAFE0001);
    checks++;
    if (sv !== 1'b1 || sf !== 1'b1 || si !== 5'd3) begin
      failures++;
      $display("FAIL dup_search got sv=%b sf=%b si=%0d want 1 1 3", sv, sf, si);
    end
`ifdef CAM_MULTI_HIT_EN
    checks++;
    if (smulti !== 1'b1 || svec !== ((D'(1) << 3) | (D'(1) << 12))) begin
      failures++;
      $display("FAIL dup_multi got multi=%b vec=%h want 1 with bits 3,12", smulti, svec);
    end
`endif
  endtask

  task automatic test_priority();
    drive(0, 1, 1, 0, 5'd7, 5'd7, 32'h11111111, '0);
    checks++;
    if (rv !== 1'b1 || rd !== 32'hDEADBEEF) begin
      failures++;
      $display("FAIL rd_over_wr got rv=%b rd=%h want 1 deadbeef", rv, rd);
    end
    drive(0, 1, 0, 0, 5'd7, '0, '0, '0);
    checks++;
    if (rd !== 32'hDEADBEEF || rh !== 1'b1) begin
      failures++;
      $display("FAIL wr_dropped got rd=%h rh=%b want deadbeef 1", rd, rh);
    end
    // write beats search: no search pulse
    drive(0, 0, 1, 1, '0, 5'd20, 32'h0BADF00D, 32'hDEADBEEF);
    checks++;
    if (sv !== 1'b0) begin
      failures++;
      $display("FAIL wr_over_srch got sv=%b want 0", sv);
    end
  endtask

  task automatic test_flush();
    drive(1, 1, 0, 1, 5'd7, '0, '0, 32'hDEADBEEF);
    checks++;
    if (rv !== 1'b0 || sv !== 1'b0) begin
      failures++;
      $display("FAIL flush_no_pulse got rv=%b sv=%b want 0 0", rv, sv);
    end
    drive(0, 1, 0, 0, 5'd7, '0, '0, '0);
    checks++;
    if (rv !== 1'b1 || rh !== 1'b0 || rd !== '0) begin
      failures++;
      $display("FAIL flush_read got rv=%b rh=%b rd=%h want 1 0 0", rv, rh, rd);
    end
    drive(0, 0, 0, 1, '0, '0, '0, 32'hDEADBEEF);
    checks++;
    if (sv !== 1'b1 || sf !== 1'b0) begin
      failures++;
      $display("FAIL flush_search got sv=%b sf=%b want 1 0", sv, sf);
    end
  endtask

  task automatic test_reset_mid_search();
    drive(0, 0, 1, 0, '0, 5'd9, 32'h5A5A5A5A, '0);
    flush = 0; re = 0; we = 1; wi = 5'd10; wd = 32'h5A5A5A5A;
    se = 1; sd = 32'h5A5A5A5A;
    #3 rst_n = 0;
    model_reset();
    @(posedge clk); #1;
    checks++;
    if ({rv, rd, rh, sv, sf, si} !== '0) begin
      failures++;
      $display("FAIL reset_mid got rv=%b rd=%h rh=%b sv=%b sf=%b si=%0d want all 0",
               rv, rd, rh, sv, sf, si);
    end
    we = 0; se = 0;
    #3 rst_n = 1;
    @(posedge clk); #1;
    drive(0, 0, 0, 1, '0, '0, '0, 32'h5A5A5A5A);
    checks++;
    if (sv !== 1'b1 || sf !== 1'b0) begin
      failures++;
      $display("FAIL reset_cleared got sv=%b sf=%b want 1 0", sv, sf);
    end
  endtask

  function automatic logic [W-1:0] pick_key();
    case ($urandom_range(0, 3))
      0:       return 32'hDEADBEEF;
      1:       return 32'hCAFE0001;
      2:       return 32'h0;
      default: return 32'h12345678;
    endcase
  endfunction

  task automatic test_random();
    for (int n = 0; n < 400; n++) begin
      bit f, r, w, s;
      f = ($urandom_range(0, 31) == 0);
      r = ($urandom_range(0, 3) == 0);
      w = ($urandom_range(0, 1) == 0);
      s = ($urandom_range(0, 1) == 0);
      drive(f, r, w, s, AW'($urandom_range(0, D-1)), AW'($urandom_range(0, D-1)),
            pick_key(), pick_key());
      checks++;
      if ({rv, rd, rh, sv, sf, si} !== {e_rv, e_rd, e_rh, e_sv, e_sf, e_si}) begin
        failures++;
        $display("FAIL rand[%0d] got rv=%b rd=%h rh=%b sv=%b sf=%b si=%0d want rv=%b rd=%h rh=%b sv=%b sf=%b si=%0d",
                 n, rv, rd, rh, sv, sf, si, e_rv, e_rd, e_rh, e_sv, e_sf, e_si);
      end
`ifdef CAM_MULTI_HIT_EN
      checks++;
      if (smulti !== (e_cnt > 1) || svec !== e_vec) begin
        failures++;
        $display("FAIL rand_multi[%0d] got multi=%b vec=%h want %b %h",
                 n, smulti, svec, (e_cnt > 1), e_vec);
      end
`endif
    end
  endtask

  initial begin
    test_reset();
    test_write_read();
    test_duplicate_search();
    test_priority();
    test_flush();
    test_reset_mid_search();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
